// File: rtl/uart_mem_dump.sv
// uart_mem_dump
//   Sweeps block-RAM addresses 0..LAST_ADR after a start pulse and sends one
//   ASCII line per 16-bit word over UART 8N1, formatted "AA:DDDD\r\n"
//   (uppercase hex).
//
// Ports
//   clock     system clock
//   reset     synchronous, active-high
//   start     one-cycle pulse that begins a dump; ignored while busy
//   mem_adr   RAM read address (held for the whole line)
//   mem_dout  RAM read data, valid one clock after mem_adr changes
//   busy      high while a dump is in progress
//   done      one-cycle pulse after the final stop bit of the final line
//   tx        UART serial output, idles high
module uart_mem_dump #(
  parameter int CLKS_PER_BIT = 868,
  parameter int LAST_ADR     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  mem_adr,
  input  logic [15:0] mem_dout,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int            CW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [7:0]    LAST       = 8'(LAST_ADR);

  typedef enum logic [2:0] {M_IDLE, M_READ, M_LATCH, M_SEND, M_NEXT, M_DONE} main_state_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  main_state_t   r_mstate, w_mstate_next;
  logic [7:0]    r_adr,    w_adr_next;
  logic [15:0]   r_word,   w_word_next;
  logic [3:0]    r_idx,    w_idx_next;

  ser_state_t    r_sstate, w_sstate_next;
  logic [CW-1:0] r_cnt,    w_cnt_next;
  logic [7:0]    r_shift,  w_shift_next;
  logic [2:0]    r_bit,    w_bit_next;
  logic          r_tx,     w_tx_next;

  logic          w_valid;
  logic          w_accept;
  logic          w_stop_last;
  logic          w_stop_penult;
  logic [7:0]    w_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character r_idx of the current line.
  always_comb begin
    case (r_idx)
      4'd0:    w_char = hex_ascii(r_adr[7:4]);
      4'd1:    w_char = hex_ascii(r_adr[3:0]);
      4'd2:    w_char = 8'h3A;
      4'd3:    w_char = hex_ascii(r_word[15:12]);
      4'd4:    w_char = hex_ascii(r_word[11:8]);
      4'd5:    w_char = hex_ascii(r_word[7:4]);
      4'd6:    w_char = hex_ascii(r_word[3:0]);
      4'd7:    w_char = 8'h0D;
      default: w_char = 8'h0A;
    endcase
  end

  assign w_stop_last   = (r_sstate == S_STOP) && (r_cnt == '0);
  assign w_stop_penult = (r_sstate == S_STOP) && (r_cnt == CNT_ONE);
  assign w_valid       = (r_mstate == M_SEND) && (r_idx != 4'd9);
  // The serializer takes a new character when idle or on the final cycle
  // of a stop bit, so characters within a line follow back to back.
  assign w_accept      = w_valid && ((r_sstate == S_IDLE) || w_stop_last);

  // Main sequencer.
  always_comb begin
    w_mstate_next = r_mstate;
    w_adr_next    = r_adr;
    w_word_next   = r_word;
    w_idx_next    = r_idx;
    done          = 1'b0;
    case (r_mstate)
      M_IDLE: begin
        if (start) begin
          w_adr_next    = 8'd0;
          w_mstate_next = M_READ;
        end
      end
      M_READ:  w_mstate_next = M_LATCH;
      M_LATCH: begin
        w_word_next   = mem_dout;
        w_idx_next    = 4'd0;
        w_mstate_next = M_SEND;
      end
      M_SEND: begin
        if (w_accept) begin
          w_idx_next = r_idx + 4'd1;
        end
        // Leave during the last stop-bit cycle of char 8: NEXT overlaps
        // that cycle, so the idle gap on tx is NEXT->READ->LATCH->SEND
        // minus one, i.e. three high cycles.
        if ((r_idx == 4'd9) && w_stop_penult) begin
          w_mstate_next = M_NEXT;
        end
      end
      M_NEXT: begin
        if (r_adr == LAST) begin
          w_mstate_next = M_DONE;
        end else begin
          w_adr_next    = r_adr + 8'd1;
          w_mstate_next = M_READ;
        end
      end
      M_DONE: begin
        done          = 1'b1;
        w_mstate_next = M_IDLE;
      end
      default: w_mstate_next = M_IDLE;
    endcase
  end

  // UART 8N1 serializer; every bit lasts BIT_RELOAD+1 cycles.
  always_comb begin
    w_sstate_next = r_sstate;
    w_cnt_next    = r_cnt;
    w_shift_next  = r_shift;
    w_bit_next    = r_bit;
    w_tx_next     = r_tx;
    case (r_sstate)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (w_accept) begin
          w_sstate_next = S_START;
          w_cnt_next    = BIT_RELOAD;
          w_shift_next  = w_char;
          w_tx_next     = 1'b0;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          w_sstate_next = S_DATA;
          w_cnt_next    = BIT_RELOAD;
          w_bit_next    = 3'd0;
          w_tx_next     = r_shift[0];
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_next = BIT_RELOAD;
          if (r_bit == 3'd7) begin
            w_sstate_next = S_STOP;
            w_tx_next     = 1'b1;
          end else begin
            w_bit_next   = r_bit + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          if (w_accept) begin
            w_sstate_next = S_START;
            w_cnt_next    = BIT_RELOAD;
            w_shift_next  = w_char;
            w_tx_next     = 1'b0;
          end else begin
            w_sstate_next = S_IDLE;
            w_tx_next     = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      default: w_sstate_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mstate <= M_IDLE;
      r_adr    <= 8'd0;
      r_word   <= 16'd0;
      r_idx    <= 4'd0;
    end else begin
      r_mstate <= w_mstate_next;
      r_adr    <= w_adr_next;
      r_word   <= w_word_next;
      r_idx    <= w_idx_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sstate <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= 8'd0;
      r_bit    <= 3'd0;
      r_tx     <= 1'b1;
    end else begin
      r_sstate <= w_sstate_next;
      r_cnt    <= w_cnt_next;
      r_shift  <= w_shift_next;
      r_bit    <= w_bit_next;
      r_tx     <= w_tx_next;
    end
  end

  assign mem_adr = r_adr;
  assign busy    = (r_mstate != M_IDLE);
  assign tx      = r_tx;

endmodule

// File: tb/tb_uart_mem_dump.sv
// tb_uart_mem_dump
//   Three instances with different bit times and sweep lengths share one
//   clock. A timing model derives every cycle's expected tx/busy/done/mem_adr
//   from the line format and frame rules; a UART receiver decodes tx so the
//   resulting text can be compared with literal strings.
module tb_uart_mem_dump;

  localparam int N = 3;
  localparam int CPB_P  [N] = '{4, 2, 3};
  localparam int LAST_P [N] = '{0, 255, 5};

  logic        clk;
  logic        rst      [N];
  logic        st       [N];
  logic [7:0]  adr      [N];
  logic [15:0] dout     [N];
  logic        busy     [N];
  logic        done     [N];
  logic        tx       [N];
  logic [15:0] ram      [N][256];

  int          cyc = 0;
  bit          act      [N];
  int          t        [N];
  logic [7:0]  idle_adr [N];

  int          checks   = 0;
  int          failures = 0;
  int          done_cnt [N];
  bit          rx_on    [N];
  int          rx_cnt   [N];
  logic [7:0]  rx_sh    [N];
  logic [7:0]  rxbuf    [N][4096];
  int          rxn      [N];

  uart_mem_dump #(.CLKS_PER_BIT(4), .LAST_ADR(0)) u_dut0 (
    .clock(clk), .reset(rst[0]), .start(st[0]), .mem_adr(adr[0]),
    .mem_dout(dout[0]), .busy(busy[0]), .done(done[0]), .tx(tx[0]));
  uart_mem_dump #(.CLKS_PER_BIT(2), .LAST_ADR(255)) u_dut1 (
    .clock(clk), .reset(rst[1]), .start(st[1]), .mem_adr(adr[1]),
    .mem_dout(dout[1]), .busy(busy[1]), .done(done[1]), .tx(tx[1]));
  uart_mem_dump #(.CLKS_PER_BIT(3), .LAST_ADR(5)) u_dut2 (
    .clock(clk), .reset(rst[2]), .start(st[2]), .mem_adr(adr[2]),
    .mem_dout(dout[2]), .busy(busy[2]), .done(done[2]), .tx(tx[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output block RAMs.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) dout[i] <= ram[i][adr[i]];
  end

  function automatic int done_time(input int i);
    return 3 + LAST_P[i] * (90 * CPB_P[i] + 3) + 90 * CPB_P[i];
  endfunction

  // Dump tracking: t counts cycles since the accepted start edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (rst[i]) begin
        act[i] <= 1'b0; t[i] <= 0; idle_adr[i] <= 8'd0;
      end else if (act[i]) begin
        if (t[i] == done_time(i)) begin
          act[i] <= 1'b0; idle_adr[i] <= 8'(LAST_P[i]);
        end else begin
          t[i] <= t[i] + 1;
        end
      end else if (st[i]) begin
        act[i] <= 1'b1; t[i] <= 0;
      end
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] line_char(input int i, input int a, input int c);
    logic [7:0]  av;
    logic [15:0] w;
    av = 8'(a);
    w  = ram[i][a];
    case (c)
      0: return hexc(av[7:4]);
      1: return hexc(av[3:0]);
      2: return 8'h3A;
      3: return hexc(w[15:12]);
      4: return hexc(w[11:8]);
      5: return hexc(w[7:4]);
      6: return hexc(w[3:0]);
      7: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Expected outputs in the current cycle, from the frame arithmetic:
  // 3 lead-in cycles, then lines of 90*C cycles separated by 3 idle cycles,
  // then one done cycle.
  task automatic expect_out(input int i, output logic etx, output logic eb,
                            output logic ed, output logic [7:0] ea);
    int c, u, ln, r, ch, bp;
    logic [7:0] chv;
    c = CPB_P[i];
    if (!act[i]) begin
      etx = 1'b1; eb = 1'b0; ed = 1'b0; ea = idle_adr[i];
    end else begin
      eb = 1'b1; ed = 1'b0;
      if (t[i] < 3) begin
        etx = 1'b1; ea = 8'd0;
      end else begin
        u  = t[i] - 3;
        ln = u / (90 * c + 3);
        r  = u % (90 * c + 3);
        if (r < 90 * c) begin
          ch  = r / (10 * c);
          bp  = (r % (10 * c)) / c;
          chv = line_char(i, ln, ch);
          etx = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : chv[bp - 1];
          ea  = 8'(ln);
        end else begin
          etx = 1'b1;
          if (ln == LAST_P[i]) begin
            ed = 1'b1; ea = 8'(ln);
          end else begin
            ea = 8'(ln + 1);
          end
        end
      end
    end
  endtask

  task automatic rx_step(input int i);
    int c, j;
    c = CPB_P[i];
    if (!rx_on[i]) begin
      if (tx[i] === 1'b0) begin rx_on[i] = 1'b1; rx_cnt[i] = 0; end
    end else begin
      rx_cnt[i]++;
      if ((rx_cnt[i] >= c) && (rx_cnt[i] % c == c / 2)) begin
        j = rx_cnt[i] / c;
        if (j <= 8) begin
          rx_sh[i][j - 1] = tx[i];
        end else begin
          if (rxn[i] < 4096) rxbuf[i][rxn[i]] = rx_sh[i];
          rxn[i]++;
          rx_on[i] = 1'b0;
        end
      end
    end
  endtask

  // One clock: sample at the falling edge and check every instance.
  task automatic tick();
    logic etx, eb, ed;
    logic [7:0] ea;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      expect_out(i, etx, eb, ed, ea);
      checks++;
      if ({tx[i], busy[i], done[i], adr[i]} !== {etx, eb, ed, ea}) begin
        failures++;
        $display("FAIL cycle inst=%0d cyc=%0d got tx=%b busy=%b done=%b adr=%h want tx=%b busy=%b done=%b adr=%h",
                 i, cyc, tx[i], busy[i], done[i], adr[i], etx, eb, ed, ea);
      end
      if (done[i] === 1'b1) done_cnt[i]++;
      rx_step(i);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic pulse_start(input int i, output int s);
    st[i] = 1'b1;
    s = cyc + 1;
    tick();
    st[i] = 1'b0;
  endtask

  task automatic wait_fall(input int i, input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (tx[i] === 1'b0) begin at = cyc; return; end
    end
    failures++;
    $display("FAIL wait_fall inst=%0d no start bit within %0d cycles", i, limit);
  endtask

  task automatic wait_done(input int i, input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (done[i] === 1'b1) begin at = cyc; return; end
    end
    failures++;
    $display("FAIL wait_done inst=%0d no done within %0d cycles", i, limit);
  endtask

  initial begin
    int s, f, d, rt, base;
    string l_single, l_first, l_last;
    l_single = "00:1A2F\r\n";
    l_first  = "00:0000\r\n";
    l_last   = "FF:FFFF\r\n";
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; st[i] = 1'b0; done_cnt[i] = 0;
      rx_on[i] = 1'b0; rx_cnt[i] = 0; rxn[i] = 0; rx_sh[i] = 8'd0;
      for (int a = 0; a < 256; a++) ram[i][a] = 16'd0;
    end
    ram[0][0] = 16'h1A2F;
    for (int a = 0; a < 256; a++) ram[1][a] = 16'(a * 16'h0101);
    for (int a = 0; a < 6; a++) ram[2][a] = 16'($urandom);

    // Reset, then a quiet interval.
    repeat (3) tick();
    chk("reset_tx",   32'(tx[0]),   32'd1);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_done", 32'(done[0]), 32'd0);
    chk("reset_adr",  32'(adr[0]),  32'd0);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    repeat (100) tick();
    chk("idle_done_pulses", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd0);
    chk("idle_tx", 32'(tx[1]), 32'd1);

    // Single line, then a restart five cycles after busy falls.
    for (int run = 0; run < 2; run++) begin
      pulse_start(0, s);
      wait_fall(0, 20, f);
      chk($sformatf("single%0d_first_fall", run), 32'(f - s), 32'd3);
      wait_done(0, 2000, d);
      chk($sformatf("single%0d_done_latency", run), 32'(d - s), 32'd363);
      $display("dump inst=0 run=%0d start=%0d done=%0d bytes=%0d", run, s, d, rxn[0]);
      tick();
      chk($sformatf("single%0d_busy_after_done", run), 32'(busy[0]), 32'd0);
      for (int k = 0; k < 9; k++)
        chk($sformatf("single%0d_char%0d", run, k), 32'(rxbuf[0][run * 9 + k]), 32'(l_single[k]));
      repeat (5) tick();
    end
    chk("single_done_count", 32'(done_cnt[0]), 32'd2);

    // Reset during bit 5 of char 3, then a clean dump.
    pulse_start(2, s);
    rt = 3 + 30 * 3 + 5 * 3 + int'($urandom_range(0, 2));
    while (cyc < s + rt) tick();
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    chk("midreset_tx",   32'(tx[2]),   32'd1);
    chk("midreset_busy", 32'(busy[2]), 32'd0);
    chk("midreset_done", 32'(done[2]), 32'd0);
    rx_on[2] = 1'b0; rxn[2] = 0;
    repeat (4) tick();
    pulse_start(2, s);
    wait_fall(2, 20, f);
    chk("midreset_restart_fall", 32'(f - s), 32'd3);
    wait_done(2, 5000, d);
    chk("midreset_done_latency", 32'(d - s), 32'(done_time(2)));
    $display("dump inst=2 start=%0d done=%0d bytes=%0d", s, d, rxn[2]);
    tick();
    chk("midreset_done_count", 32'(done_cnt[2]), 32'd1);
    chk("midreset_byte_count", 32'(rxn[2]), 32'd54);
    chk("midreset_line0_c0", 32'(rxbuf[2][0]), 32'h30);
    chk("midreset_line0_c1", 32'(rxbuf[2][1]), 32'h30);
    chk("midreset_line0_c2", 32'(rxbuf[2][2]), 32'h3A);
    for (int k = 0; k < 54; k++)
      chk($sformatf("midreset_text%0d", k), 32'(rxbuf[2][k]), 32'(line_char(2, k / 9, k % 9)));

    // Full sweep with ignored start pulses in line 2 and in the done cycle.
    pulse_start(1, s);
    base = 3 + 2 * (90 * 2 + 3) + int'($urandom_range(0, 179));
    while (cyc < s + base) tick();
    pulse_start(1, f);
    for (int n = 0; n < 60000; n++) begin
      if (act[1] && t[1] == done_time(1)) break;
      tick();
    end
    chk("sweep_in_done_cycle", 32'(done[1]), 32'd1);
    d = cyc;
    pulse_start(1, f);
    repeat (10) tick();
    $display("dump inst=1 start=%0d done=%0d bytes=%0d", s, d, rxn[1]);
    chk("sweep_done_latency", 32'(d - s), 32'(3 + 255 * 183 + 180));
    chk("sweep_done_count", 32'(done_cnt[1]), 32'd1);
    chk("sweep_busy_after", 32'(busy[1]), 32'd0);
    chk("sweep_byte_count", 32'(rxn[1]), 32'd2304);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("sweep_line0_char%0d", k),   32'(rxbuf[1][k]),           32'(l_first[k]));
      chk($sformatf("sweep_line255_char%0d", k), 32'(rxbuf[1][255 * 9 + k]), 32'(l_last[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
